// File: rtl/msi_arb_pkg.sv
// -----------------------------------------------------------------------------
// msi_arb_pkg
// Shared definitions for the MSI arbiter: the build configuration (requester
// count and IRQ code width), the holding-slot record and the round-robin
// index type. The slot and index types are sized from this configuration.
// The module parameters of msi_arbiter default to these values and must
// agree with them.
// -----------------------------------------------------------------------------
package msi_arb_pkg;

   localparam int ARB_SRC_NUM_POW = 2;
   localparam int ARB_IRQ_NUM_POW = 4;

   // Number of requesters for a given log2 count.
   function automatic int src_num(input int pow);
      return 1 << pow;
   endfunction

   localparam int ARB_SRC_NUM = src_num(ARB_SRC_NUM_POW);

   // Round-robin pointer / grant index.
   typedef logic [ARB_SRC_NUM_POW-1:0] rr_idx_t;

   // One-entry holding slot per requester.
   typedef struct packed {
      logic                       vld;
      logic [ARB_IRQ_NUM_POW-1:0] code;
   } slot_t;

endpackage

// File: rtl/msi_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Picks the first set bit of the
// eligible vector starting at rr_ptr_i and wrapping around.
//
// Ports:
//   elig_i    in   SRC_NUM      eligible sources
//   rr_ptr_i  in   SRC_NUM_POW  index with highest priority this cycle
//   gnt_o     out  SRC_NUM_POW  granted index (valid when gnt_vld_o)
//   gnt_vld_o out  1            at least one source is eligible
// -----------------------------------------------------------------------------
module rr_picker
   import msi_arb_pkg::*;
#(
   parameter int SRC_NUM_POW = ARB_SRC_NUM_POW
) (
   input  logic [src_num(SRC_NUM_POW)-1:0] elig_i,
   input  logic [SRC_NUM_POW-1:0]          rr_ptr_i,
   output logic [SRC_NUM_POW-1:0]          gnt_o,
   output logic                            gnt_vld_o
);

   localparam int SRC_NUM = src_num(SRC_NUM_POW);

   logic [2*SRC_NUM-1:0]   dbl;
   logic [SRC_NUM-1:0]     rot;
   logic [SRC_NUM_POW-1:0] off;

   // Rotating a doubled copy right by rr_ptr_i puts index rr_ptr_i at bit 0,
   // so a plain lowest-bit priority encode yields the distance from rr_ptr_i.
   always_comb begin
      // NOTE: every signal gets a value before any branch, so no latch can be inferred.
      dbl = {elig_i, elig_i} >> rr_ptr_i;
      rot = dbl[SRC_NUM-1:0];
      off = '0;
      for (int i = SRC_NUM - 1; i >= 0; i--) begin
         if (rot[i]) off = SRC_NUM_POW'(i);
      end
      // Sum wraps naturally in SRC_NUM_POW bits (modulo SRC_NUM).
      gnt_o     = rr_ptr_i + off;
      gnt_vld_o = |elig_i;
   end

endmodule

// File: rtl/msi_arbiter.sv
// -----------------------------------------------------------------------------
// msi_arbiter
// Shares the single MSI injection port of the tile interrupt adapter between
// SRC_NUM requesters. Each requester owns a one-entry holding slot filled
// through a req/ack handshake; a round-robin scheduler drains the slots at up
// to one MSI per cycle. A slot drained in a cycle can be refilled in the same
// cycle, so a single source can sustain one MSI per cycle.
//
// Ports:
//   clk_i        in   1                      clock
//   rst_i        in   1                      synchronous reset, active-high
//   src_en_bi    in   SRC_NUM                per-source enable
//   src_req_bi   in   SRC_NUM                per-source request, held until acked
//   src_code_bi  in   SRC_NUM*IRQ_NUM_POW    flattened codes, source i at [i*W +: W]
//   src_ack_bo   out  SRC_NUM                per-source accept (combinational)
//   pause_i      in   1                      suppress grants; slots still fill
//   msi_req_o    out  1                      registered one-cycle MSI pulse
//   msi_code_bo  out  IRQ_NUM_POW            registered code for msi_req_o
//   pend_bo      out  SRC_NUM                registered slot valid bits
// -----------------------------------------------------------------------------
module msi_arbiter
   import msi_arb_pkg::*;
#(
   parameter int SRC_NUM_POW = ARB_SRC_NUM_POW,
   parameter int IRQ_NUM_POW = ARB_IRQ_NUM_POW
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [src_num(SRC_NUM_POW)-1:0]           src_en_bi,
   input  logic [src_num(SRC_NUM_POW)-1:0]           src_req_bi,
   input  logic [src_num(SRC_NUM_POW)*IRQ_NUM_POW-1:0] src_code_bi,
   output logic [src_num(SRC_NUM_POW)-1:0]           src_ack_bo,
   input  logic                                      pause_i,
   output logic                                      msi_req_o,
   output logic [IRQ_NUM_POW-1:0]                    msi_code_bo,
   output logic [src_num(SRC_NUM_POW)-1:0]           pend_bo
);

   localparam int SRC_NUM = src_num(SRC_NUM_POW);

   // Registered state
   slot_t                  slot_q [SRC_NUM];
   slot_t                  slot_d [SRC_NUM];
   rr_idx_t                rr_ptr_q, rr_ptr_d;
   logic                   msi_req_q, msi_req_d;
   logic [IRQ_NUM_POW-1:0] msi_code_q, msi_code_d;
   logic [SRC_NUM-1:0]     pend_q, pend_d;

   // Combinational scheduling signals
   logic [SRC_NUM-1:0]     vld;
   logic [SRC_NUM-1:0]     elig;
   logic [SRC_NUM-1:0]     gnt_oh;
   logic [SRC_NUM-1:0]     ack;
   rr_idx_t                gnt;
   logic                   gnt_vld;

   always_comb begin
      vld = '0;
      for (int i = 0; i < SRC_NUM; i++) vld[i] = slot_q[i].vld;
      // A disabled slot keeps its entry but is never offered to the picker.
      elig = vld & src_en_bi & {SRC_NUM{!pause_i}};
   end

   rr_picker #(
      .SRC_NUM_POW (SRC_NUM_POW)
   ) u_rr_picker (
      .elig_i    (elig),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_vld_o (gnt_vld)
   );

   // Accept into an empty slot, or into the slot being drained this cycle.
   always_comb begin
      gnt_oh = '0;
      if (gnt_vld) gnt_oh[gnt] = 1'b1;
      ack = rst_i ? '0 : (src_req_bi & src_en_bi & (~vld | gnt_oh));
   end

   always_comb begin
      slot_d     = slot_q;
      rr_ptr_d   = rr_ptr_q;
      msi_req_d  = gnt_vld;
      msi_code_d = '0;
      pend_d     = '0;

      if (gnt_vld) begin
         msi_code_d       = slot_q[gnt].code;
         slot_d[gnt].vld  = 1'b0;
         rr_ptr_d         = gnt + rr_idx_t'(1);
      end

      // Applied after the grant clear so a same-cycle refill wins.
      for (int i = 0; i < SRC_NUM; i++) begin
         if (ack[i]) begin
            slot_d[i].vld  = 1'b1;
            slot_d[i].code = src_code_bi[i*IRQ_NUM_POW +: IRQ_NUM_POW];
         end
         pend_d[i] = slot_d[i].vld;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the slot array is a handful of flops, not RAM, so it is reset
         // explicitly; a stale valid bit would otherwise emit a phantom MSI.
         for (int i = 0; i < SRC_NUM; i++) slot_q[i] <= '0;
         rr_ptr_q   <= '0;
         msi_req_q  <= 1'b0;
         msi_code_q <= '0;
         pend_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         slot_q     <= slot_d;
         rr_ptr_q   <= rr_ptr_d;
         msi_req_q  <= msi_req_d;
         msi_code_q <= msi_code_d;
         pend_q     <= pend_d;
      end
   end

   assign src_ack_bo  = ack;
   assign msi_req_o   = msi_req_q;
   assign msi_code_bo = msi_code_q;
   assign pend_bo     = pend_q;

endmodule

// File: tb/tb_msi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_msi_arbiter
// Self-checking bench for msi_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a behavioural reference model
// (pending table + round-robin scan), with a few explicit value checks.
// -----------------------------------------------------------------------------
module tb_msi_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N-1:0]   src_en_bi;
   logic [N-1:0]   src_req_bi;
   logic [N*W-1:0] src_code_bi;
   logic [N-1:0]   src_ack_bo;
   logic           pause_i;
   logic           msi_req_o;
   logic [W-1:0]   msi_code_bo;
   logic [N-1:0]   pend_bo;

   msi_arbiter #(
      .SRC_NUM_POW (2),
      .IRQ_NUM_POW (W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .src_en_bi   (src_en_bi),
      .src_req_bi  (src_req_bi),
      .src_code_bi (src_code_bi),
      .src_ack_bo  (src_ack_bo),
      .pause_i     (pause_i),
      .msi_req_o   (msi_req_o),
      .msi_code_bo (msi_code_bo),
      .pend_bo     (pend_bo)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit           m_vld [N];
   int           m_code[N];
   int           m_rr;
   bit           m_req;
   int           m_mcode;
   int           m_gnt;
   logic [N-1:0] exp_ack;
   logic [N-1:0] last_ack;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Grant and accept decisions for the current cycle from the model state.
   function automatic void model_eval();
      m_gnt   = -1;
      exp_ack = '0;
      if (rst_i) return;
      if (!pause_i) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (m_gnt < 0 && m_vld[idx] && src_en_bi[idx] == 1'b1) m_gnt = idx;
         end
      end
      for (int i = 0; i < N; i++)
         exp_ack[i] = src_req_bi[i] && src_en_bi[i] && (!m_vld[i] || m_gnt == i);
   endfunction

   function automatic void model_update();
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            m_vld[i]  = 1'b0;
            m_code[i] = 0;
         end
         m_rr = 0; m_req = 1'b0; m_mcode = 0;
         return;
      end
      if (m_gnt >= 0) begin
         m_req   = 1'b1;
         m_mcode = m_code[m_gnt];
         m_vld[m_gnt] = 1'b0;
         m_rr    = (m_gnt + 1) % N;
      end else begin
         m_req   = 1'b0;
         m_mcode = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (exp_ack[i]) begin
            m_vld[i]  = 1'b1;
            m_code[i] = int'(src_code_bi[i*W +: W]);
         end
      end
   endfunction

   // One clock cycle: check the accept mid-cycle, then the registered outputs
   // just after the edge (those are the values of the following cycle).
   task automatic tick();
      logic [N-1:0] p;
      #1;
      model_eval();
      last_ack = src_ack_bo;
      check("ack", 32'(src_ack_bo), 32'(exp_ack));
      @(posedge clk_i);
      model_update();
      #1;
      p = '0;
      for (int i = 0; i < N; i++) p[i] = m_vld[i];
      check("msi_req",  32'(msi_req_o),   32'(m_req));
      check("msi_code", 32'(msi_code_bo), 32'(m_mcode));
      check("pend",     32'(pend_bo),     32'(p));
   endtask

   task automatic drop_acked();
      for (int i = 0; i < N; i++) if (exp_ack[i]) src_req_bi[i] = 1'b0;
   endtask

   task automatic set_code(input int i, input int c);
      src_code_bi[i*W +: W] = W'(c);
   endtask

   task automatic do_reset();
      rst_i = 1'b1; src_req_bi = '0; pause_i = 1'b0; src_en_bi = '1;
      tick(); tick();
      rst_i = 1'b0;
   endtask

   int saw9, saw10;

   initial begin
      rst_i = 1'b1; src_en_bi = '1; src_req_bi = '0; src_code_bi = '0; pause_i = 1'b0;
      for (int i = 0; i < N; i++) begin m_vld[i] = 1'b0; m_code[i] = 0; end
      m_rr = 0; m_req = 1'b0; m_mcode = 0; m_gnt = -1; exp_ack = '0; last_ack = '0;

      // Reset state, with a request held during reset (must not be acked).
      src_req_bi = 4'b1111;
      tick();
      check("rst_ack",  32'(last_ack),  32'd0);
      check("rst_pend", 32'(pend_bo),   32'd0);
      check("rst_req",  32'(msi_req_o), 32'd0);
      do_reset();

      // Single source: ack in cycle 1, pend in cycle 2, MSI in cycle 3 only.
      src_req_bi[2] = 1'b1; set_code(2, 5);
      tick();
      check("s1_ack", 32'(last_ack), 32'b0100);
      check("s1_pend_c2", 32'(pend_bo), 32'b0100);
      check("s1_req_c2",  32'(msi_req_o), 32'd0);
      src_req_bi = '0;
      tick();
      check("s1_req_c3",  32'(msi_req_o),   32'd1);
      check("s1_code_c3", 32'(msi_code_bo), 32'd5);
      tick();
      check("s1_req_c4",  32'(msi_req_o), 32'd0);

      // All four continuously requesting: codes rotate 1,2,3,4,...
      do_reset();
      src_req_bi = '1;
      for (int i = 0; i < N; i++) set_code(i, i + 1);
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k >= 1) begin
            check("s2_req",  32'(msi_req_o),   32'd1);
            check("s2_code", 32'(msi_code_bo), 32'(((k - 1) % 4) + 1));
         end
      end
      src_req_bi = '0;
      repeat (6) tick();

      // Backpressure under pause.
      do_reset();
      pause_i = 1'b1; src_req_bi[0] = 1'b1; set_code(0, 7);
      tick();
      check("s3_ack7", 32'(last_ack[0]), 32'd1);
      set_code(0, 8);
      repeat (3) begin
         tick();
         check("s3_hold", 32'(last_ack[0]), 32'd0);
      end
      pause_i = 1'b0;
      tick();
      check("s3_ack8", 32'(last_ack[0]), 32'd1);
      check("s3_msi7", 32'(msi_code_bo), 32'd7);
      src_req_bi = '0;
      tick();
      check("s3_msi8", 32'(msi_code_bo), 32'd8);
      tick();

      // Disable retains the entry; re-enable issues it.
      do_reset();
      src_req_bi[1] = 1'b1; set_code(1, 9);
      tick();
      src_req_bi[1] = 1'b0; src_en_bi[1] = 1'b0;
      src_req_bi[3] = 1'b1; set_code(3, 10);
      saw9 = 0; saw10 = 0;
      repeat (5) begin
         tick(); drop_acked();
         if (msi_req_o && msi_code_bo == 4'd9)  saw9++;
         if (msi_req_o && msi_code_bo == 4'd10) saw10++;
      end
      check("s4_no9",  32'(saw9),  32'd0);
      check("s4_10",   32'(saw10), 32'd1);
      src_en_bi[1] = 1'b1;
      repeat (3) begin
         tick();
         if (msi_req_o && msi_code_bo == 4'd9) saw9++;
      end
      check("s4_9", 32'(saw9), 32'd1);

      // Reset mid-operation discards slots and restarts the pointer.
      do_reset();
      src_req_bi[0] = 1'b1; set_code(0, 1);
      tick(); drop_acked(); tick(); tick();
      pause_i = 1'b1;
      src_req_bi = 4'b0111; set_code(0, 1); set_code(1, 2); set_code(2, 3);
      tick(); drop_acked();
      check("s5_pend", 32'(pend_bo), 32'b0111);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; pause_i = 1'b0;
      check("s5_pend_rst", 32'(pend_bo), 32'd0);
      tick(); tick();
      check("s5_quiet", 32'(msi_req_o), 32'd0);
      src_req_bi = 4'b0101; set_code(0, 11); set_code(2, 12);
      tick(); drop_acked();
      tick();
      check("s5_first",  32'(msi_code_bo), 32'd11);
      tick();
      check("s5_second", 32'(msi_code_bo), 32'd12);
      tick();

      // Same-cycle drain and refill of one slot.
      do_reset();
      src_req_bi[0] = 1'b1; set_code(0, 3);
      tick();
      set_code(0, 6);
      tick();
      check("s6_refill_ack", 32'(last_ack[0]), 32'd1);
      check("s6_msi3", 32'(msi_code_bo), 32'd3);
      src_req_bi = '0;
      tick();
      check("s6_msi6_req", 32'(msi_req_o),   32'd1);
      check("s6_msi6",     32'(msi_code_bo), 32'd6);
      tick();

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_i   = ($urandom_range(0, 199) == 0);
         pause_i = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) src_en_bi[i] = ~src_en_bi[i];
            if (!src_req_bi[i] && $urandom_range(0, 1) == 1) begin
               src_req_bi[i] = 1'b1;
               set_code(i, int'($urandom_range(0, 15)));
            end
         end
         tick();
         drop_acked();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/msi_arbiter.md
Name: msi_arbiter

Overview:
- Shares the single MSI injection port (msi_req / msi_code) of the tile interrupt adapter between SRC_NUM independent requesters, such as DMA, timers and neighbour tiles.
- Each requester gets a one-entry holding slot with a req/ack handshake.
- A round-robin scheduler drains the slots at up to one MSI per cycle.
- Sits between the on-tile MSI sources and the interrupt adapter's msi_req_i/msi_code_bi inputs.

Parameters:
- SRC_NUM_POW, 2, log2 of the number of requesters (SRC_NUM = 2**SRC_NUM_POW).
- IRQ_NUM_POW, 4, width of the IRQ code; must match the interrupt adapter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- src_en_bi  in  SRC_NUM  per-source enable; a disabled source is neither acked nor granted.
- src_req_bi  in  SRC_NUM  per-source MSI request; held until acked.
- src_code_bi  in  SRC_NUM*IRQ_NUM_POW  flattened codes; source i occupies bits [i*IRQ_NUM_POW +: IRQ_NUM_POW].
- src_ack_bo  out  SRC_NUM  per-source accept, combinational.
- pause_i  in  1  when high, no grant is issued; slots keep accepting until full.
- msi_req_o  out  1  registered one-cycle MSI pulse toward the interrupt adapter.
- msi_code_bo  out  IRQ_NUM_POW  registered code accompanying msi_req_o.
- pend_bo  out  SRC_NUM  registered; holding-slot valid bits, for status/debug.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - all slot valid bits 0, slot codes 0, rr_ptr 0.
  - msi_req_o 0, msi_code_bo 0, pend_bo 0.
  - Reset mid-operation discards every pending entry; no MSI is emitted for it.
  - src_ack_bo is 0 while rst_i=1.
- Slot i state: vld[i], code[i].
- Grant (combinational, on registered state):
  - Eligible sources: vld[i] & src_en_bi[i], and pause_i=0.
  - gnt = first eligible index scanning rr_ptr, rr_ptr+1, ... wrapping modulo SRC_NUM.
  - gnt_vld = at least one eligible source.
- Accept (combinational):
  - src_ack_bo[i] = src_req_bi[i] & src_en_bi[i] & (!vld[i] | (gnt_vld & gnt==i)).
  - A slot drained in cycle t may be refilled in the same cycle t. This gives 1 MSI/cycle per source at full rate.
- Sequential update per clock edge, when not in reset:
  - If gnt_vld:
    - msi_req_o <= 1, msi_code_bo <= code[gnt], vld[gnt] <= 0.
    - rr_ptr <= gnt+1, wrapping to 0 after SRC_NUM-1.
  - Otherwise msi_req_o <= 0, msi_code_bo <= 0, and rr_ptr is unchanged.
  - For each i with src_ack_bo[i]: vld[i] <= 1, code[i] <= src code i. This has priority over the grant clear for the same slot.
  - pend_bo <= next value of vld.
- Latency: ack in cycle t, then slot valid at t+1, then at earliest msi_req_o=1 during t+2 (grant decided in t+1, output registered at the edge ending t+1).
- Fairness: with all SRC_NUM sources continuously requesting, grants rotate strictly 0,1,2,3,0,... Each source waits at most SRC_NUM-1 grants.
- Enable cleared while a slot is valid:
  - the entry is retained but not granted.
  - it is issued after re-enable.
- pause_i:
  - stops grants and rr_ptr.
  - non-full slots still ack.
  - full slots backpressure (no ack).
- Duplicate codes from different sources are not merged; each produces its own msi_req_o pulse. The interrupt adapter flags are idempotent.
- msi_req_o is never high for two different codes in one cycle. Codes are passed unmodified.

Decomposition:
- Package msi_arb_pkg holds:
  - localparam functions for SRC_NUM;
  - a typedef for the slot struct {vld, code};
  - a typedef for the rr index.
- One sub-module, rr_picker: purely combinational.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: gnt, gnt_vld.
  - Implemented as a double-width rotate and priority encode.
- msi_arbiter instantiates rr_picker and holds all registers.

Test Plan:
- Single source: src 2 requests code 5 in cycle 1 → src_ack_bo=4'b0100 in cycle 1; msi_req_o=1 with msi_code_bo=5 in cycle 3 only; pend_bo[2] high in cycle 2.
- All 4 sources request continuously (codes 1,2,3,4) from reset → msi_code_bo sequence 1,2,3,4,1,2,... with msi_req_o high every cycle after the first 2 cycles.
- Backpressure: pause_i=1, src 0 issues 2 requests (codes 7, 8) → first acked, second held without ack. Release pause → MSI 7, then 8 acked and issued 2 cycles later.
- Disable: src 1 slot valid (code 9), src_en_bi[1]=0 for 5 cycles while src 3 sends code 10 → only code 10 issued; after re-enable, code 9 is issued.
- Reset mid-operation: 3 slots valid, rst_i pulsed for 1 cycle → msi_req_o stays 0 afterwards and pend_bo=0; rr_ptr restarts, so the next simultaneous requests from sources 0 and 2 are served as 0 then 2.
- Same-cycle drain/refill: src 0 holds code 3 and is granted while requesting code 6 → ack in that cycle; MSIs 3 then 6 appear on consecutive cycles when no other source is pending.
